// File: rtl/mem_copy_dma.sv
// Word-by-word RAM-to-RAM copy engine: one READ and one WRITE cycle per word, ascending order.
// Optional build macro MEM_COPY_FILL_EN adds a fill mode that writes a constant at one cycle per word.
module mem_copy_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] srcAddr_q;
    logic [ADDR_W-1:0] dstAddr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] memAddress_q;
    logic [DATA_W-1:0] memIn_q;
    logic              memLoad_q;
`ifdef MEM_COPY_FILL_EN
    logic              fill_q;
`endif

    logic [ADDR_W:0]   idxNext_d;
    logic              moreWords_d;
    logic [ADDR_W-1:0] curDstAddr_d;
    logic [ADDR_W-1:0] nextSrcAddr_d;
    logic [ADDR_W-1:0] nextDstAddr_d;

    // Addresses deliberately truncate to ADDR_W bits so regions wrap around the top of memory.
    always_comb begin
        idxNext_d     = idx_q + 1'b1;
        moreWords_d   = (idxNext_d < len_q);
        curDstAddr_d  = dstAddr_q + idx_q[ADDR_W-1:0];
        nextSrcAddr_d = srcAddr_q + idxNext_d[ADDR_W-1:0];
        nextDstAddr_d = dstAddr_q + idxNext_d[ADDR_W-1:0];
    end

    // All outputs are registered: the values for the next state are set on the transition into it.
    // memIn_q doubles as the captured-data register, so the word read is exactly the word written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            srcAddr_q    <= '0;
            dstAddr_q    <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            memAddress_q <= '0;
            memIn_q      <= '0;
            memLoad_q    <= 1'b0;
`ifdef MEM_COPY_FILL_EN
            fill_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            srcAddr_q <= src_addr;
                            dstAddr_q <= dst_addr;
                            len_q     <= length;
                            idx_q     <= '0;
                            busy_q    <= 1'b1;
`ifdef MEM_COPY_FILL_EN
                            fill_q    <= fill;
                            if (fill) begin
                                state_q      <= WRITE;
                                memAddress_q <= dst_addr;
                                memIn_q      <= fill_value;
                                memLoad_q    <= 1'b1;
                            end else begin
                                state_q      <= READ;
                                memAddress_q <= src_addr;
                            end
`else
                            state_q      <= READ;
                            memAddress_q <= src_addr;
`endif
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q      <= WRITE;
                    memAddress_q <= curDstAddr_d;
                    memIn_q      <= mem_out;
                    memLoad_q    <= 1'b1;
                end
                WRITE: begin
                    idx_q <= idxNext_d;
                    if (moreWords_d) begin
`ifdef MEM_COPY_FILL_EN
                        if (fill_q) begin
                            memAddress_q <= nextDstAddr_d;
                        end else begin
                            state_q      <= READ;
                            memAddress_q <= nextSrcAddr_d;
                            memIn_q      <= '0;
                            memLoad_q    <= 1'b0;
                        end
`else
                        state_q      <= READ;
                        memAddress_q <= nextSrcAddr_d;
                        memIn_q      <= '0;
                        memLoad_q    <= 1'b0;
`endif
                    end else begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        memAddress_q <= '0;
                        memIn_q      <= '0;
                        memLoad_q    <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef MEM_COPY_FILL_EN
    logic unusedNextDst;
    assign unusedNextDst = ^nextDstAddr_d;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_address = memAddress_q;
    assign mem_in      = memIn_q;
    assign mem_load    = memLoad_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: expected RAM writes and done cycles are queued at issue time
// and a negedge monitor pops and compares them whenever the DUT writes or pulses done.
module tb_mem_copy_dma;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   length;
`ifdef MEM_COPY_FILL_EN
    logic              fill;
    logic [DATA_W-1:0] fill_value;
`endif
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [DATA_W-1:0] mem_out;

    logic [DATA_W-1:0] ram [0:4095];
    logic              preloadEn;
    logic [ADDR_W-1:0] preloadAddr;
    logic [DATA_W-1:0] preloadData;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t expWrites[$];
    int  expDone[$];
    wr_t popW;
    int  popDone;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycCount    = 0;
    int busyCycles  = 0;
    int loadCycles  = 0;
    int acc;

    always #5 clk = ~clk;

    mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
`ifdef MEM_COPY_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .mem_address(mem_address),
        .mem_in     (mem_in),
        .mem_load   (mem_load),
        .mem_out    (mem_out)
    );

    // Zero-latency read RAM model; preload port lets the bench seed words from the same process.
    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        cycCount <= cycCount + 1;
        if (preloadEn) ram[preloadAddr] <= preloadData;
        else if (mem_load) ram[mem_address] <= mem_in;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got 0x%0h, want none", name, actual);
    endtask

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (busy === 1'b1) busyCycles++;
        if (mem_load === 1'b1) begin
            loadCycles++;
            if (expWrites.size() == 0) begin
                reportUnexpected("unexpected_write", {20'd0, mem_address});
            end else begin
                popW = expWrites.pop_front();
                checkOutput("wr_addr", {20'd0, mem_address}, {20'd0, popW.addr});
                checkOutput("wr_data", {16'd0, mem_in}, {16'd0, popW.data});
            end
        end
        if (done === 1'b1) begin
            if (expDone.size() == 0) begin
                reportUnexpected("unexpected_done", cycCount);
            end else begin
                popDone = expDone.pop_front();
                checkOutput("done_cycle", cycCount, popDone);
                checkOutput("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        @(negedge clk);
        preloadEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                                 input logic [ADDR_W:0] len, output int accept);
        @(negedge clk);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        length   = len;
`ifdef MEM_COPY_FILL_EN
        fill     = 1'b0;
`endif
        @(posedge clk);
        #1;
        accept = cycCount;
        start  = 1'b0;
    endtask

    task automatic expectWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        expWrites.push_back(w);
    endtask

    task automatic drain(input string name, input int cycles);
        repeat (cycles) @(negedge clk);
        checkOutput({name, "_writes_drained"}, expWrites.size(), 32'd0);
        checkOutput({name, "_done_seen"}, expDone.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got stuck, want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        preloadEn = 1'b0; preloadAddr = '0; preloadData = '0;
`ifdef MEM_COPY_FILL_EN
        fill = 1'b0; fill_value = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_load", {31'd0, mem_load}, 32'd0);
        checkOutput("rst_addr", {20'd0, mem_address}, 32'd0);
        checkOutput("rst_data", {16'd0, mem_in}, 32'd0);
        reset = 1'b0;

        // Basic four-word copy
        for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), 16'hA001 + 16'(i));
        for (int i = 0; i < 4; i++) expectWrite(12'h800 + 12'(i), 16'hA001 + 16'(i));
        busyCycles = 0;
        applyStimulus(12'h010, 12'h800, 13'd4, acc);
        expDone.push_back(acc + 8);
        drain("basic", 12);
        checkOutput("basic_busy_cycles", busyCycles, 32'd8);
        for (int i = 0; i < 4; i++)
            checkOutput("basic_ram", {16'd0, ram[12'h800 + 12'(i)]}, {16'd0, 16'hA001 + 16'(i)});

        // Zero length: done on the next cycle, no memory traffic
        loadCycles = 0;
        applyStimulus(12'h123, 12'h456, 13'd0, acc);
        expDone.push_back(acc);
        drain("zero", 4);
        checkOutput("zero_no_load", loadCycles, 32'd0);

        // Source wraps from 0xFFF to 0x000
        preload(12'hFFE, 16'd1);
        preload(12'hFFF, 16'd2);
        preload(12'h000, 16'd3);
        preload(12'h001, 16'd4);
        for (int i = 0; i < 4; i++) expectWrite(12'h002 + 12'(i), 16'(i + 1));
        applyStimulus(12'hFFE, 12'h002, 13'd4, acc);
        expDone.push_back(acc + 8);
        drain("wrap", 12);
        for (int i = 0; i < 4; i++)
            checkOutput("wrap_ram", {16'd0, ram[12'h002 + 12'(i)]}, 32'(i + 1));

        // A second start while busy is ignored
        preload(12'h040, 16'h1111);
        preload(12'h041, 16'h2222);
        preload(12'h042, 16'h3333);
        expectWrite(12'h600, 16'h1111);
        expectWrite(12'h601, 16'h2222);
        expectWrite(12'h602, 16'h3333);
        busyCycles = 0;
        applyStimulus(12'h040, 12'h600, 13'd3, acc);
        expDone.push_back(acc + 6);
        repeat (2) @(negedge clk);
        start = 1'b1; src_addr = 12'h0AA; dst_addr = 12'h700; length = 13'd5;
        @(negedge clk);
        start = 1'b0;
        drain("ignore", 12);
        checkOutput("ignore_busy_cycles", busyCycles, 32'd6);
        checkOutput("ignore_ram2", {16'd0, ram[12'h602]}, 32'h3333);

        // Reset during the WRITE of word 2 of an 8-word copy
        for (int i = 0; i < 8; i++) preload(12'h080 + 12'(i), 16'hB000 + 16'(i));
        preload(12'h303, 16'hDEAD);
        for (int i = 0; i < 3; i++) expectWrite(12'h300 + 12'(i), 16'hB000 + 16'(i));
        applyStimulus(12'h080, 12'h300, 13'd8, acc);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_load", {31'd0, mem_load}, 32'd0);
        drain("abort", 20);
        checkOutput("abort_ram2", {16'd0, ram[12'h302]}, 32'hB002);
        checkOutput("abort_ram3", {16'd0, ram[12'h303]}, 32'hDEAD);
        expectWrite(12'h310, 16'hB000);
        applyStimulus(12'h080, 12'h310, 13'd1, acc);
        expDone.push_back(acc + 2);
        drain("restart", 6);
        checkOutput("restart_ram", {16'd0, ram[12'h310]}, 32'hB000);

`ifdef MEM_COPY_FILL_EN
        // Fill mode: one cycle per word
        for (int i = 0; i < 3; i++) expectWrite(12'h100 + 12'(i), 16'h5A5A);
        @(negedge clk);
        start = 1'b1; src_addr = 12'h000; dst_addr = 12'h100; length = 13'd3;
        fill = 1'b1; fill_value = 16'h5A5A;
        @(posedge clk);
        #1;
        acc = cycCount;
        start = 1'b0; fill = 1'b0;
        expDone.push_back(acc + 3);
        drain("fill", 8);
        for (int i = 0; i < 3; i++)
            checkOutput("fill_ram", {16'd0, ram[12'h100 + 12'(i)]}, 32'h5A5A);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 12: memory address width, matching a 4096-word RAM.
REQ-002 Parameter DATA_W, default 16: memory word width.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request a copy; sampled only in IDLE.
REQ-006 Port src_addr, input, ADDR_W: first source address; latched on an accepted start.
REQ-007 Port dst_addr, input, ADDR_W: first destination address; latched on an accepted start.
REQ-008 Port length, input, ADDR_W+1: word count 0..4096; latched on an accepted start.
REQ-009 Port busy, output, 1: high while in READ or WRITE.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port mem_address, output, ADDR_W: drives the RAM address.
REQ-012 Port mem_in, output, DATA_W: drives the RAM write data.
REQ-013 Port mem_load, output, 1: drives the RAM write enable.
REQ-014 Port mem_out, input, DATA_W: RAM read data, combinational from mem_address with zero-cycle latency.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-016 In IDLE with start=1 and length>0, the block SHALL latch src_addr, dst_addr and length, clear the word index i to 0 and enter READ.
REQ-017 In IDLE with start=1 and length=0, the block SHALL enter DONE directly and perform no memory access.
REQ-018 In READ, the block SHALL drive mem_address=src+i and mem_load=0, and on the clock edge capture mem_out into a data register, then enter WRITE.
REQ-019 In WRITE, the block SHALL drive mem_address=dst+i, mem_in=the captured data and mem_load=1, then increment i.
REQ-020 After WRITE, the next state SHALL be READ if i+1<length, otherwise DONE.
REQ-021 In DONE, the block SHALL assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-022 Each word SHALL take exactly 2 cycles; done SHALL assert 2*length+1 cycles after the accepting edge (1 cycle when length=0).
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_W, so src+i and dst+i wrap from 4095 to 0.
REQ-024 Copy order SHALL be strictly ascending.
REQ-025 Overlapping regions with dst>src SHALL propagate already-written words; this is defined behaviour.
REQ-026 start SHALL be ignored in READ, WRITE and DONE.
REQ-027 mem_load SHALL be 0 in every state except WRITE.
REQ-028 mem_address and mem_in SHALL be 0 in IDLE and DONE.
REQ-029 length=4096 SHALL copy the full memory.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL enter IDLE and clear i, the latched parameters and the data register.
REQ-031 Reset SHALL take priority over start and over any in-progress state.
REQ-032 After reset, busy, done and mem_load SHALL be 0, and mem_address and mem_in SHALL be 0.
REQ-033 Reset during WRITE SHALL abort the copy with no done pulse; the write of the current cycle still occurs, because the RAM samples mem_load on that same edge.

Configuration
REQ-034 When macro MEM_COPY_FILL_EN is defined, the block SHALL add input ports fill (1 bit) and fill_value (DATA_W), both latched on an accepted start.
REQ-035 With MEM_COPY_FILL_EN defined and fill=1, the block SHALL skip READ and write fill_value to dst+i in WRITE, at 1 cycle per word; done SHALL assert length+1 cycles after the accepting edge.
REQ-036 With MEM_COPY_FILL_EN undefined, the fill and fill_value ports SHALL be absent and only copy behaviour SHALL exist.

Verification
REQ-037 Preload RAM[0x010..0x013]=0xA001..0xA004; start with src=0x010, dst=0x800, length=4 -> RAM[0x800..0x803]=0xA001..0xA004, done asserted 9 cycles after accept, busy high for 8 cycles.
REQ-038 start with length=0 -> done asserted on the next cycle, mem_load never asserted.
REQ-039 src=0xFFE, dst=0x002, length=4 with RAM[0xFFE,0xFFF,0x000,0x001]=1,2,3,4 -> RAM[0x002..0x005]=1,2,3,4; source address wraps from 0xFFF to 0x000.
REQ-040 Assert reset in the WRITE cycle of word 2 of a length-8 copy -> only words 0..2 written, no done pulse, block in IDLE; a new start is then accepted.
REQ-041 Pulse start again while busy with different parameters -> ignored; the original copy completes unchanged.
REQ-042 With MEM_COPY_FILL_EN defined: fill=1, fill_value=0x5A5A, dst=0x100, length=3 -> RAM[0x100..0x102]=0x5A5A, done asserted 4 cycles after accept.
